// File: rtl/vga_sprite_pos_loader.sv
// vga_sprite_pos_loader: vblank-triggered sprite position table loader with atomic commit
module vga_sprite_pos_loader #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] POS_BASE    = ADDR_WIDTH'(16'h8000),
    parameter int                    NUM_SPRITES = 4,
    parameter int                    COORD_WIDTH = 10,
    parameter int                    RD_LATENCY  = 1
) (
    input  logic                               sys_clk,
    input  logic                               reset_n,
    input  logic                               vblank_start,
    input  logic                               load_enable,
    output logic [ADDR_WIDTH-1:0]              ram_addr,
    output logic                               ram_rd_en,
    input  logic [15:0]                        ram_q,
    output logic                               busy,
    output logic                               load_done,
    output logic [NUM_SPRITES*COORD_WIDTH-1:0] pos_x_flat,
    output logic [NUM_SPRITES*COORD_WIDTH-1:0] pos_y_flat,
    output logic [NUM_SPRITES*16-1:0]          attr_flat,
    output logic [NUM_SPRITES-1:0]             visible,
    output logic [15:0]                        frame_count
);
    localparam int TOTAL = 3 * NUM_SPRITES;
    localparam int IW    = $clog2(TOTAL);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, COMMIT} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic [1:0]    wcnt;
    logic [15:0]   shadow [TOTAL];

    assign busy      = state != IDLE;
    assign ram_rd_en = busy;
    assign ram_addr  = busy ? POS_BASE + ADDR_WIDTH'(idx) : '0;

    // Next-state: one ISSUE/WAIT/CAPTURE pass per word, then a single COMMIT
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vblank_start && load_enable) state_nx = ISSUE;
            ISSUE:   state_nx = (RD_LATENCY > 1) ? WAIT : CAPTURE;
            WAIT:    if (int'(wcnt) == RD_LATENCY - 2) state_nx = CAPTURE;
            CAPTURE: state_nx = (idx == IW'(TOTAL - 1)) ? COMMIT : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    // Visibility is the attribute MSB of each live record
    always_comb begin
        visible = '0;
        for (int i = 0; i < NUM_SPRITES; i++) visible[i] = attr_flat[i*16+15];
    end

    // Control: state, word index and read-latency wait counter
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (state == WAIT) ? wcnt + 2'd1 : 2'd0;
            if (state == IDLE) idx <= '0;
            else if (state == CAPTURE && state_nx == ISSUE) idx <= idx + 1'b1;
        end
    end

    // Shadow table fills word by word and is never visible at the outputs
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TOTAL; i++) shadow[i] <= '0;
        end else if (state == CAPTURE) begin
            shadow[idx] <= ram_q;
        end
    end

    // Live outputs switch over in one edge so consumers never see a mixed frame
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_flat  <= '0;
            pos_y_flat  <= '0;
            attr_flat   <= '0;
            load_done   <= 1'b0;
            frame_count <= '0;
        end else begin
            load_done <= state == COMMIT;
            if (state == COMMIT) begin
                frame_count <= frame_count + 16'd1;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    pos_x_flat[i*COORD_WIDTH +: COORD_WIDTH] <= shadow[3*i][COORD_WIDTH-1:0];
                    pos_y_flat[i*COORD_WIDTH +: COORD_WIDTH] <= shadow[3*i+1][COORD_WIDTH-1:0];
                    attr_flat[i*16 +: 16]                    <= shadow[3*i+2];
                end
            end
        end
    end
endmodule

// File: doc/vga_sprite_pos_loader.md
# vga_sprite_pos_loader

Parametrised vblank position loader for the VGA path. On each vertical-blank pulse it reads a table of NUM_SPRITES three-word records (X, Y, attribute) from the shared single-port sprite/position RAM into shadow registers, then commits them atomically so sprite helpers never see a half-updated frame. It sits between the VGA timing generator and the sprite fetch logic. While `busy` is high it owns the RAM read port.

## Interface
- ADDR_WIDTH, 16, RAM address width
- POS_BASE, 16'h8000, address of record 0 word 0
- NUM_SPRITES, 4, number of records (1..16)
- COORD_WIDTH, 10, width of each X/Y output
- RD_LATENCY, 1, RAM read latency in cycles (1..3)

- sys_clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- vblank_start  in  1  one-cycle pulse at start of vertical blank
- load_enable  in  1  1 = accept vblank_start; 0 = freeze current positions
- ram_addr  out  ADDR_WIDTH  read address to RAM port B
- ram_rd_en  out  1  high while loader drives ram_addr
- ram_q  in  16  RAM read data
- busy  out  1  loader owns RAM port; sprite fetch must be suppressed
- load_done  out  1  one-cycle pulse when new positions become live
- pos_x_flat  out  NUM_SPRITES*COORD_WIDTH  live X, sprite i at [i*COORD_WIDTH +: COORD_WIDTH]
- pos_y_flat  out  NUM_SPRITES*COORD_WIDTH  live Y, same packing
- attr_flat  out  NUM_SPRITES*16  live attribute words
- visible  out  NUM_SPRITES  visible[i] = attr word i bit 15
- frame_count  out  16  number of completed commits, wraps at 16'hFFFF -> 0

## Operation
- TOTAL = 3*NUM_SPRITES words. Word k sits at POS_BASE + k. Record i = words 3i (X), 3i+1 (Y), 3i+2 (attr).
- States:
  - IDLE: go to ISSUE on `vblank_start && load_enable`. The word index is cleared to 0.
  - ISSUE: one cycle. Go to WAIT if RD_LATENCY > 1, else to CAPTURE.
  - WAIT: RD_LATENCY-1 cycles, then CAPTURE.
  - CAPTURE: latch ram_q into shadow word[idx]. If idx == TOTAL-1 go to COMMIT, else increment idx and go to ISSUE.
  - COMMIT: copy all shadow words to the live outputs in the same edge. Pulse load_done, increment frame_count, return to IDLE.
- busy = ram_rd_en = (state != IDLE), combinational.
- ram_addr = POS_BASE + idx while busy, 0 in IDLE. It stays stable through ISSUE, WAIT and CAPTURE of each word. Address addition wraps modulo 2^ADDR_WIDTH.
- X/Y outputs take the low COORD_WIDTH bits of their word; upper bits are ignored. Attribute words are kept as full 16 bits.
- Live outputs change only in COMMIT. Shadow contents are never visible at the outputs.
- vblank_start while busy is ignored and does not restart the load.
- vblank_start with load_enable = 0 is ignored; outputs hold their values.
- load_enable falling mid-load has no effect; the load completes.

## Timing
- Reset (async assert, sync release): state IDLE, idx 0, and every output 0 (ram_addr, ram_rd_en, busy, load_done, pos_x_flat, pos_y_flat, attr_flat, visible, frame_count). Shadow registers are cleared.
- Reset asserted mid-load aborts the load. Shadow data is discarded and the live outputs read 0, so all sprites are invisible.
- Pulse sampled at edge T0:
  - busy is high from cycle T0+1.
  - Each word takes RD_LATENCY+1 cycles.
  - COMMIT occupies cycle T0+1+TOTAL*(RD_LATENCY+1).
- load_done is high in the cycle after the COMMIT edge, together with the new live values. busy is low in that same cycle.
- Total busy cycles = TOTAL*(RD_LATENCY+1) + 1. This is 25 for the defaults and must be less than the vblank length.
- RAM model: the address sampled at edge E returns data valid for capture at edge E+RD_LATENCY.

## Test plan
- Defaults. RAM[8000..800B] = X0=5, Y0=7, A0=8000, ..., X3=3FF, Y3=1E0, A3=0. Pulse vblank_start -> busy for exactly 25 cycles with ram_addr stepping 8000..800B every 2 cycles. After load_done: pos_x_flat[39:30]=3FF, visible=4'b0111, frame_count=1.
- Atomicity. Change the RAM contents and pulse again. Check the outputs hold the old values every cycle until the load_done cycle, then all sprites change in the same cycle.
- RD_LATENCY=3, NUM_SPRITES=2 -> 6 words at 4 cycles each plus COMMIT = 25 busy cycles, and the correct words are captured.
- Extra vblank_start pulses at busy cycles 3 and 24 -> ignored, a single load_done, frame_count increments by 1. With load_enable=0, a pulse gives no busy and no change.
- Assert reset_n=0 at busy cycle 10 -> all outputs 0 immediately. The next pulse performs a full clean load.
- X word = FFFF -> pos_x = 3FF (truncated). POS_BASE=FFFE -> addresses FFFE, FFFF, 0000, ... wrap correctly. Preload frame_count to FFFF by forcing commits -> next commit reads 0.
